// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data-memory responder.
// State encoding plus word and lane geometry.
package data_mem_pkg;

    localparam int WORD_W = 32;
    localparam int LANES  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } dmr_state_t;

endpackage

// File: rtl/data_mem_array.sv
// Single-port word RAM with per-byte write enables and a registered read.
// The read register clears on reset; the array itself is never reset.
module data_mem_array
    import data_mem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en,
    input  logic              clr,
    input  logic [LANES-1:0]  we,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Commit each enabled byte lane of the write word.
    always_ff @(posedge clk) begin
        for (int l = 0; l < LANES; l++) begin
            if (we[l]) begin
                mem[addr][8*l +: 8] <= wdata[8*l +: 8];
            end
        end
    end

    // Capture the addressed word (or zero for a rejected access).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (rd_en) begin
            rdata <= clr ? '0 : mem[addr];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: wait-state FSM in front of a word RAM.
// Optional out-of-range checking: DATA_MEM_RESP_RANGE_CHECK_EN.
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rd_i,
    input  logic              wr_i,
    input  logic [31:0]       addr_i,
    input  logic [WORD_W-1:0] data_i,
    input  logic [LANES-1:0]  byte_select_i,
    output logic              ready_o,
    output logic [WORD_W-1:0] data_o,
    output logic              err_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] CNT_LOAD =
        (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    dmr_state_t       state;
    logic [3:0]       cnt;
    logic             req;
    logic             in_range;
    logic             rd_en;
    logic [LANES-1:0] we;
    logic [AW-1:0]    idx;

    assign req = rd_i | wr_i;
    assign idx = addr_i[AW+1:2];

`ifdef DATA_MEM_RESP_RANGE_CHECK_EN
    assign in_range = (addr_i >> (AW + 2)) == 32'd0;
`else
    assign in_range = 1'b1;
`endif

    assign rd_en = (state == IDLE && req && WAIT_STATES == 0)
                || (state == WAIT && cnt == 4'd0);

    assign we = (state == DONE && wr_i && in_range)
              ? byte_select_i : '0;

    // Ready is high when idle without a request or on the completing cycle.
    always_comb begin
        ready_o = 1'b0;
        unique case (state)
            IDLE:    ready_o = ~req;
            WAIT:    ready_o = 1'b0;
            DONE:    ready_o = 1'b1;
            default: ready_o = 1'b0;
        endcase
    end

    // Access sequencing: IDLE -> WAIT (counted) -> DONE -> IDLE.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req) begin
                        if (WAIT_STATES > 0) begin
                            state <= WAIT;
                            cnt   <= CNT_LOAD;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DATA_MEM_RESP_RANGE_CHECK_EN
    // Sticky flag for any access completed outside the array.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            err_o <= 1'b0;
        end else if (state == DONE && !in_range) begin
            err_o <= 1'b1;
        end
    end
`else
    assign err_o = 1'b0;
`endif

    data_mem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk   (clk_i),
        .rst_n (rst_i),
        .rd_en (rd_en),
        .clr   (~in_range),
        .we    (we),
        .addr  (idx),
        .wdata (data_i),
        .rdata (data_o)
    );

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Word-organised data memory that serves the CPU's data-memory port as the responder end of that interface. It decodes `data_mem_rd_o`/`data_mem_wr_o`/`byte_select_o`/`data_mem_addr_o`/`data_mem_data_o`, inserts a configurable number of wait states by pulling `ready_o` low, and then completes the access. `ready_o` connects to the CPU's `data_mem_ready_i`, so this block's stalls freeze the whole CPU pipeline.

## Interface
Parameters:
- `DEPTH`, 1024: number of 32-bit words; must be a power of two.
- `WAIT_STATES`, 2: extra stall cycles per access (0..15).

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset; one clock; reset is asynchronous and active-low.
- `rd_i`  in  1  read request (level), from CPU `data_mem_rd_o`.
- `wr_i`  in  1  write request (level), from CPU `data_mem_wr_o`.
- `addr_i`  in  32  byte address; bits [1:0] ignored.
- `data_i`  in  32  write data, already lane-aligned.
- `byte_select_i`  in  4  write byte enables; bit n gates `data_i[8n+7:8n]`.
- `ready_o`  out  1  access complete / responder idle; to CPU `data_mem_ready_i`.
- `data_o`  out  32  read data (full word).
- `err_o`  out  1  sticky out-of-range flag (see Configuration).

## Operation
- States: IDLE, WAIT, DONE. A request is `req = rd_i | wr_i`.
- IDLE: `ready_o = ~req`. If req: go to WAIT when `WAIT_STATES > 0`, loading counter = `WAIT_STATES-1`; otherwise go directly to DONE.
- WAIT: `ready_o = 0`. Decrement the counter; go to DONE when counter == 0.
- DONE: `ready_o = 1` for exactly one cycle. On that clock edge:
  - Write: commit enabled bytes at word index `addr_i[$clog2(DEPTH)+1:2]`.
  - Read: `data_o` already holds the word, registered on the WAIT→DONE or IDLE→DONE edge.
  - Then return to IDLE unconditionally.
- After DONE, a request still present in IDLE is a new access, even at the same address, and stalls again. This matches the CPU, which advances exactly one stage on each high-`ready_o` edge.
- `rd_i` and `wr_i` both high: treat as a write. `data_o` returns the pre-write word.
- `byte_select_i == 0` with `wr_i`: full handshake, no array change.
- Inputs are guaranteed stable while `ready_o` is low; the block samples address/data only on the DONE-entry edge and the DONE edge.
- `data_o` holds its last value outside DONE.
- Reset (asynchronous, any state): state → IDLE, counter → 0, `data_o` → 0, `err_o` → 0. An in-flight write is dropped. Array contents are not reset. `ready_o` after reset equals `~req`.

## Timing
- Stall per access: `WAIT_STATES + 1` cycles of `ready_o = 0`, then 1 cycle with `ready_o = 1`.
- Example, WAIT_STATES=2, request appears at cycle 0:
  - `ready_o` low in cycles 0–2.
  - `ready_o` high in cycle 3, with `data_o` valid.
  - The write is committed at the end of cycle 3.
- WAIT_STATES=0: `ready_o` low in cycle 0, high in cycle 1.
- No request: `ready_o` stays high continuously and there are zero stall cycles.
- Read-after-write to the same word in consecutive accesses returns the new data.

## Configuration
- `DATA_MEM_RESP_RANGE_CHECK_EN` defined:
  - An access with `addr_i >= 4*DEPTH` completes the normal handshake.
  - Writes are suppressed and reads return 0.
  - `err_o` is set on the DONE edge and stays set until reset.
- Not defined: the address wraps modulo `DEPTH` and `err_o` is tied to 0.

## Structure
- Shared package `data_mem_pkg` contains:
  - the state encoding `dmr_state_t` (IDLE=2'd0, WAIT=2'd1, DONE=2'd2);
  - `WORD_W = 32` and `LANES = 4`.
- Sub-module `data_mem_array`: single-port synchronous RAM with per-byte write enable and a registered read. It is instantiated once; the FSM, counter and error logic live in the top module.

## Test plan
- Idle, no request for 10 cycles → `ready_o` = 1 every cycle, `data_o` = 0 after reset.
- WAIT_STATES=2: write 0xA5A5_1234 to 0x10 with byte_select 4'hF, then read 0x10 → each access shows 3 low cycles then 1 high; the read returns 0xA5A5_1234.
- Byte lanes: word at 0x20 = 0x1122_3344; write 0x0000_AA00 with byte_select 4'b0010 → read returns 0x1122_AA44.
- Back-to-back reads of the same address with `rd_i` held high → two separate 3-low/1-high handshakes; identical data.
- Assert `rst_i` low during WAIT of a write to 0x30 (prior value 0x0) → `ready_o`=~req, `data_o`=0, and a later read of 0x30 returns 0x0.
- With `DATA_MEM_RESP_RANGE_CHECK_EN` and DEPTH=1024: write to 0x1000 then read 0x1000 → read = 0, `err_o` rises on the first DONE and stays 1. Without the macro: the read returns the written value and also aliases address 0x0.
